motor_cmd_sequencer: RTL and testbench

MOTOR_CMD_SEQUENCER -- requirements
Module: motor_cmd_sequencer

---
 rtl/motor_cmd_sequencer.sv | 172 +++++++++++++++++
 tb/tb_motor_cmd_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : motor_cmd_sequencer
// Purpose  : Arbitrates manual/autonomous drive requests into PWM-gated
//            H-bridge drives with dwell, dead-time and a manual watchdog.
// Revision : 1.0  initial release
// ============================================================================
module motor_cmd_sequencer #(
    parameter int DEAD_CYCLES = 8,
    parameter int MIN_DWELL   = 64,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] auto_cmd,
    input  logic       auto_valid,
    input  logic [1:0] man_cmd,
    input  logic       man_valid,
    input  logic       man_mode,
    input  logic [3:0] duty,
    output logic       motor_a_fwd,
    output logic       motor_a_rev,
    output logic       motor_b_fwd,
    output logic       motor_b_rev,
    output logic [1:0] state_o,
    output logic [1:0] cur_cmd,
    output logic       wdog_trip
);

    localparam int DW_W = $clog2(MIN_DWELL + 1);
    localparam int DE_W = $clog2(DEAD_CYCLES + 1);
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    state_t          r_state, w_state_nx;
    logic [1:0]      r_cur, w_cur_nx;
    logic [1:0]      r_pend, w_pend_nx;
    logic [DW_W-1:0] r_dwell, w_dwell_nx;
    logic [DE_W-1:0] r_dead, w_dead_nx;
    logic [3:0]      r_pwm, w_pwm_nx;
    logic [WD_W-1:0] r_wdog;
    logic            r_trip;
    logic            r_mode_prev;
    logic [3:0]      r_drv;   // {a_fwd, a_rev, b_fwd, b_rev}

    logic       w_req_valid;
    logic [1:0] w_req_cmd;
    logic       w_mode_chg;
    logic       w_wdog_expire;
    logic       w_move;
    logic       w_force_idle;

    // ena low is folded in as a valid standby request from either source
    assign w_req_valid   = ~ena | (man_mode ? man_valid : auto_valid);
    assign w_req_cmd     = ~ena ? 2'b00 : (man_mode ? man_cmd : auto_cmd);
    assign w_mode_chg    = man_mode ^ r_mode_prev;
    assign w_wdog_expire = man_mode & ~man_valid & ~w_mode_chg &
                           (r_wdog == WD_W'(WDOG_CYCLES - 1));
    assign w_move        = w_req_valid & (w_req_cmd != 2'b00);
    assign w_force_idle  = (w_req_valid & (w_req_cmd == 2'b00)) | w_mode_chg | w_wdog_expire;

    always_comb begin
        w_state_nx = r_state;
        w_cur_nx   = r_cur;
        w_pend_nx  = r_pend;
        w_dwell_nx = r_dwell;
        w_dead_nx  = r_dead;
        w_pwm_nx   = r_pwm;
        case (r_state)
            ST_IDLE: begin
                if (w_move) begin
                    w_state_nx = ST_RUN;
                    w_cur_nx   = w_req_cmd;
                    w_dwell_nx = '0;
                    w_pwm_nx   = '0;
                end
            end
            ST_RUN: begin
                if (w_force_idle) begin
                    w_state_nx = ST_IDLE;
                end else if (w_move && (w_req_cmd != r_cur) &&
                             (r_dwell == DW_W'(MIN_DWELL))) begin
                    w_state_nx = ST_DEAD;
                    w_pend_nx  = w_req_cmd;
                    w_dead_nx  = '0;
                end else begin
                    if (r_dwell != DW_W'(MIN_DWELL))
                        w_dwell_nx = r_dwell + 1'b1;
                    w_pwm_nx = r_pwm + 1'b1;
                end
            end
            ST_DEAD: begin
                if (w_force_idle) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    if (w_move)
                        w_pend_nx = w_req_cmd;
                    // a request landing in the final dead cycle is still honoured
                    if (r_dead == DE_W'(DEAD_CYCLES - 1)) begin
                        w_state_nx = ST_RUN;
                        w_cur_nx   = w_pend_nx;
                        w_dwell_nx = '0;
                        w_pwm_nx   = '0;
                    end else begin
                        w_dead_nx = r_dead + 1'b1;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cur       <= '0;
            r_pend      <= '0;
            r_dwell     <= '0;
            r_dead      <= '0;
            r_pwm       <= '0;
            r_wdog      <= '0;
            r_trip      <= 1'b0;
            r_mode_prev <= 1'b0;
            r_drv       <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_cur       <= w_cur_nx;
            r_pend      <= w_pend_nx;
            r_dwell     <= w_dwell_nx;
            r_dead      <= w_dead_nx;
            r_pwm       <= w_pwm_nx;
            r_mode_prev <= man_mode;

            if (!man_mode || man_valid || w_mode_chg || w_wdog_expire)
                r_wdog <= '0;
            else
                r_wdog <= r_wdog + 1'b1;

            if (man_valid)
                r_trip <= 1'b0;
            else if (w_wdog_expire)
                r_trip <= 1'b1;

            // one-hot per motor side, so fwd and rev can never coincide
            r_drv <= 4'b0000;
            if ((r_state == ST_RUN) && (r_pwm < duty)) begin
                case (r_cur)
                    2'b01:   r_drv <= 4'b1010;
                    2'b10:   r_drv <= 4'b1001;
                    2'b11:   r_drv <= 4'b0110;
                    default: r_drv <= 4'b0000;
                endcase
            end
        end
    end

    assign motor_a_fwd = r_drv[3];
    assign motor_a_rev = r_drv[2];
    assign motor_b_fwd = r_drv[1];
    assign motor_b_rev = r_drv[0];
    assign state_o     = r_state;
    assign cur_cmd     = (r_state == ST_RUN) ? r_cur : 2'b00;
    assign wdog_trip   = r_trip;

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_cmd_sequencer
// Purpose  : Directed plus randomized checks of motor_cmd_sequencer against
//            a cycle-level behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_motor_cmd_sequencer;

    localparam int DEAD = 8;
    localparam int MIN  = 64;
    localparam int WDOG = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [1:0] auto_cmd = 2'b00;
    logic       auto_valid = 1'b0;
    logic [1:0] man_cmd = 2'b00;
    logic       man_valid = 1'b0;
    logic       man_mode = 1'b0;
    logic [3:0] duty = 4'd0;
    logic       motor_a_fwd, motor_a_rev, motor_b_fwd, motor_b_rev;
    logic [1:0] state_o, cur_cmd;
    logic       wdog_trip;

    motor_cmd_sequencer #(
        .DEAD_CYCLES(DEAD),
        .MIN_DWELL  (MIN),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .auto_cmd   (auto_cmd),
        .auto_valid (auto_valid),
        .man_cmd    (man_cmd),
        .man_valid  (man_valid),
        .man_mode   (man_mode),
        .duty       (duty),
        .motor_a_fwd(motor_a_fwd),
        .motor_a_rev(motor_a_rev),
        .motor_b_fwd(motor_b_fwd),
        .motor_b_rev(motor_b_rev),
        .state_o    (state_o),
        .cur_cmd    (cur_cmd),
        .wdog_trip  (wdog_trip)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: state 0 idle, 1 run, 2 dead; counters are plain cycle counts
    int         m_st, m_cur, m_pend, m_dwell, m_dead, m_pwm, m_wd;
    bit         m_trip, m_mprev;
    logic [3:0] m_drv;

    wire [3:0] drv = {motor_a_fwd, motor_a_rev, motor_b_fwd, motor_b_rev};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] drive_of(input int dir);
        case (dir)
            1:       return 4'b1010;
            2:       return 4'b1001;
            3:       return 4'b0110;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 0; m_cur = 0; m_pend = 0; m_dwell = 0; m_dead = 0;
        m_pwm = 0; m_wd = 0; m_trip = 0; m_mprev = 0; m_drv = 4'b0000;
    endtask

    task automatic enter_run(input int dir);
        m_st = 1; m_cur = dir; m_dwell = 0; m_pwm = 0;
    endtask

    task automatic model_step();
        bit sv, mc, expire, fidle, mv;
        int sc;
        sv     = !ena || (man_mode ? man_valid : auto_valid);
        sc     = !ena ? 0 : int'(man_mode ? man_cmd : auto_cmd);
        mc     = (man_mode != m_mprev);
        expire = man_mode && !man_valid && !mc && (m_wd + 1 == WDOG);
        fidle  = (sv && sc == 0) || mc || expire;
        mv     = sv && sc != 0;
        m_drv  = (m_st == 1 && m_pwm < int'(duty)) ? drive_of(m_cur) : 4'b0000;
        if (!man_mode || man_valid || mc || expire) m_wd = 0;
        else m_wd++;
        if (man_valid) m_trip = 0;
        else if (expire) m_trip = 1;
        m_mprev = man_mode;
        case (m_st)
            0: if (mv) enter_run(sc);
            1: begin
                if (fidle) m_st = 0;
                else if (mv && sc != m_cur && m_dwell >= MIN) begin
                    m_pend = sc; m_st = 2; m_dead = 0;
                end else begin
                    m_dwell = (m_dwell + 1 > MIN) ? MIN : m_dwell + 1;
                    m_pwm   = (m_pwm + 1) % 16;
                end
            end
            default: begin
                if (fidle) m_st = 0;
                else begin
                    if (mv) m_pend = sc;
                    m_dead++;
                    if (m_dead == DEAD) enter_run(m_pend);
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("state", 32'(state_o), 32'(m_st));
        chk("cur_cmd", 32'(cur_cmd), (m_st == 1) ? 32'(m_cur) : 32'd0);
        chk("drives", 32'(drv), 32'(m_drv));
        chk("wdog_trip", 32'(wdog_trip), 32'(m_trip));
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_drives", 32'(drv), 32'd0);
        chk("rst_cur", 32'(cur_cmd), 32'd0);
        chk("rst_trip", 32'(wdog_trip), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (!(motor_a_fwd && motor_a_rev) && !(motor_b_fwd && motor_b_rev)) else begin
                errors++;
                $error("FAIL shoot_through observed=%b expected=no fwd&rev pair", drv);
            end
        end
    end

    initial begin
        int n;
        model_reset();
        #3;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_drives", 32'(drv), 32'd0);
        chk("reset_trip", 32'(wdog_trip), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1;
        duty = 4'd15;

        // auto forward with duty 15: on for pwm 0..14, off at 15
        auto_cmd = 2'b01; auto_valid = 1'b1;
        step();
        auto_valid = 1'b0;
        step();
        chk("fwd_on", 32'(drv), 32'hA);
        repeat (14) step();
        step();
        chk("pwm15_off", 32'(drv), 32'h0);

        // right held from early dwell: ignored until dwell expiry, then dead time
        auto_cmd = 2'b10; auto_valid = 1'b1;
        n = 0;
        while (!(m_st == 1 && m_cur == 2) && n < 200) begin step(); n++; end
        step();
        chk("right_on", 32'(drv), 32'h9);
        chk("right_cur", 32'(cur_cmd), 32'd2);

        // during dead time left then right: right wins, length unchanged
        auto_cmd = 2'b01;
        n = 0;
        while (m_st != 2 && n < 200) begin step(); n++; end
        chk("reach_dead", 32'(state_o), 32'd2);
        n = 1;
        auto_cmd = 2'b11; step(); if (state_o == 2'b10) n++;
        auto_cmd = 2'b10; step(); if (state_o == 2'b10) n++;
        auto_valid = 1'b0;
        for (int k = 0; k < 20 && state_o == 2'b10; k++) begin
            step();
            if (state_o == 2'b10) n++;
        end
        chk("dead_len", 32'(n), 32'd8);
        chk("dead_last_writer", 32'(cur_cmd), 32'd2);

        // manual watchdog
        man_mode = 1'b1;
        step();
        chk("mode_idle", 32'(state_o), 32'd0);
        man_cmd = 2'b01; man_valid = 1'b1;
        step();
        man_valid = 1'b0;
        repeat (1030) step();
        chk("wdog_set", 32'(wdog_trip), 32'd1);
        chk("wdog_idle", 32'(state_o), 32'd0);
        man_valid = 1'b1;
        step();
        man_valid = 1'b0;
        chk("wdog_clear", 32'(wdog_trip), 32'd0);
        chk("wdog_rerun", 32'(state_o), 32'd1);
        repeat (5) step();

        // mode change in RUN
        man_mode = 1'b0;
        step();
        chk("toggle_idle", 32'(state_o), 32'd0);

        // duty 0 keeps RUN with drives off
        duty = 4'd0; auto_cmd = 2'b11; auto_valid = 1'b1;
        repeat (20) step();
        chk("duty0_run", 32'(state_o), 32'd1);
        chk("duty0_off", 32'(drv), 32'h0);
        duty = 4'd9;

        // async reset mid dead time
        auto_cmd = 2'b01;
        n = 0;
        while (m_st != 2 && n < 200) begin step(); n++; end
        repeat (3) step();
        async_reset();
        auto_valid = 1'b0;
        repeat (3) step();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            ena        = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 199) == 0) man_mode = ~man_mode;
            auto_valid = ($urandom_range(0, 9) == 0);
            auto_cmd   = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            man_valid  = ($urandom_range(0, 9) == 0);
            man_cmd    = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) duty = 4'($urandom_range(0, 15));
            step();
            if ($urandom_range(0, 999) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
